// File: rtl/phase_sequencer.sv
// Five-stage, non-overlapped instruction phase sequencer with a HALT state.
// One instruction walks FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK.
// Each stage is held while its stall input is high.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   stall_<stage>         stage not done; hold in that state
//   halt_req              stop after the current instruction retires
//   phase_<stage>         combinational output-register enable, high in the
//                         last cycle of the named state
//   phase_state           current state code (FETCH=0 .. WRITEBACK=4, HALT=5)
//   halted                high while in HALT
//   cycle_cnt             non-halted cycle count (performance counter)
//   instret_cnt           retired instruction count (performance counter)
//
// Parameters:
//   CNT_WIDTH             width of the performance counters
//   HALT_ON_RESET         1: leave reset into HALT, 0: leave reset into FETCH
//
// Build option: define PHASE_SEQUENCER_PERF_CNT_EN to implement the
// performance counters. Without it both counters are tied to 0.
module phase_sequencer #(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_fetch,
  input  logic                 stall_decode,
  input  logic                 stall_execute,
  input  logic                 stall_memory,
  input  logic                 stall_writeback,
  input  logic                 halt_req,
  output logic                 phase_fetch,
  output logic                 phase_decode,
  output logic                 phase_execute,
  output logic                 phase_memory,
  output logic                 phase_writeback,
  output logic [2:0]           phase_state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam state_t RESET_STATE = HALT_ON_RESET ? S_HALT : S_FETCH;

  state_t state;

  // State register; halt_req is only consulted when WRITEBACK completes or in HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        S_FETCH:     if (!stall_fetch)   state <= S_DECODE;
        S_DECODE:    if (!stall_decode)  state <= S_EXECUTE;
        S_EXECUTE:   if (!stall_execute) state <= S_MEMORY;
        S_MEMORY:    if (!stall_memory)  state <= S_WRITEBACK;
        S_WRITEBACK: if (!stall_writeback) state <= halt_req ? S_HALT : S_FETCH;
        S_HALT:      if (!halt_req)      state <= S_FETCH;
        default:     state <= S_FETCH;   // unused codes recover to FETCH
      endcase
    end
  end

  // Phase enables: last cycle of each stage state; forced low during reset.
  always_comb begin
    phase_fetch     = 1'b0;
    phase_decode    = 1'b0;
    phase_execute   = 1'b0;
    phase_memory    = 1'b0;
    phase_writeback = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH:     phase_fetch     = !stall_fetch;
        S_DECODE:    phase_decode    = !stall_decode;
        S_EXECUTE:   phase_execute   = !stall_execute;
        S_MEMORY:    phase_memory    = !stall_memory;
        S_WRITEBACK: phase_writeback = !stall_writeback;
        default:     ;
      endcase
    end
  end

  assign phase_state = state;
  assign halted      = (state == S_HALT);

`ifdef PHASE_SEQUENCER_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;

  // Free-wrapping counters; a retire is exactly a phase_writeback pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != S_HALT) cycle_q   <= cycle_q + CNT_WIDTH'(1);
      if (phase_writeback) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed, table-driven bench for phase_sequencer (CNT_WIDTH=4 instance plus
// a HALT_ON_RESET=1 instance).
module tb_phase_sequencer;

`ifdef PHASE_SEQUENCER_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // stall/ph bit order: {writeback, memory, execute, decode, fetch}
  typedef struct packed {
    logic [4:0] stall;
    logic       halt;
    logic [4:0] ph;
    logic [2:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] stall = 5'b0;
  logic       halt_req = 1'b0;
  logic       pf, pd, pe, pm, pw, halted;
  logic [2:0] phase_state;
  logic [3:0] cycle_cnt, instret_cnt;
  logic [4:0] ph;

  logic        rst_h = 1'b1;
  logic        halt_h = 1'b0;
  logic        hpf, hpd, hpe, hpm, hpw, halted_h;
  logic [2:0]  state_h;
  logic [31:0] cyc_h, ins_h;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_cyc = 4'd0;
  logic [3:0] exp_ins = 4'd0;
  vec_t vq[$];

  always #5 clk = ~clk;
  assign ph = {pw, pm, pe, pd, pf};

  phase_sequencer #(.CNT_WIDTH(4), .HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst),
    .stall_fetch(stall[0]), .stall_decode(stall[1]), .stall_execute(stall[2]),
    .stall_memory(stall[3]), .stall_writeback(stall[4]), .halt_req(halt_req),
    .phase_fetch(pf), .phase_decode(pd), .phase_execute(pe),
    .phase_memory(pm), .phase_writeback(pw),
    .phase_state(phase_state), .halted(halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  phase_sequencer #(.CNT_WIDTH(32), .HALT_ON_RESET(1'b1)) dut_h (
    .clk(clk), .rst(rst_h),
    .stall_fetch(1'b0), .stall_decode(1'b0), .stall_execute(1'b0),
    .stall_memory(1'b0), .stall_writeback(1'b0), .halt_req(halt_h),
    .phase_fetch(hpf), .phase_decode(hpd), .phase_execute(hpe),
    .phase_memory(hpm), .phase_writeback(hpw),
    .phase_state(state_h), .halted(halted_h),
    .cycle_cnt(cyc_h), .instret_cnt(ins_h)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [4:0] s, input logic h, input logic [4:0] p, input logic [2:0] st);
    vec_t v;
    v.stall = s; v.halt = h; v.ph = p; v.st = st;
    vq.push_back(v);
  endtask

  // Drive one cycle's inputs, check before the next rising edge, advance the model.
  task automatic run_vec(input vec_t v, input string tag);
    stall    = v.stall;
    halt_req = v.halt;
    #1;
    chk({tag, " phase"}, 32'(ph), 32'(v.ph));
    chk({tag, " state"}, 32'(phase_state), 32'(v.st));
    chk({tag, " halted"}, 32'(halted), 32'(v.st == 3'd5));
    chk({tag, " cycle_cnt"}, 32'(cycle_cnt), PERF ? 32'(exp_cyc) : 32'd0);
    chk({tag, " instret_cnt"}, 32'(instret_cnt), PERF ? 32'(exp_ins) : 32'd0);
    if (v.st != 3'd5) exp_cyc = exp_cyc + 4'd1;
    if (v.ph[4])      exp_ins = exp_ins + 4'd1;
  endtask

  initial begin
    vec_t v;
    // Loop 1: no stalls.
    add(5'b00000, 0, 5'b00001, 0); add(5'b00000, 0, 5'b00010, 1);
    add(5'b00000, 0, 5'b00100, 2); add(5'b00000, 0, 5'b01000, 3);
    add(5'b00000, 0, 5'b10000, 4);
    // Loop 2: decode stalled 3 cycles, stall_memory ignored in DECODE.
    add(5'b00000, 0, 5'b00001, 0); add(5'b00010, 0, 5'b00000, 1);
    add(5'b00010, 0, 5'b00000, 1); add(5'b01010, 0, 5'b00000, 1);
    add(5'b01000, 0, 5'b00010, 1); add(5'b00000, 0, 5'b00100, 2);
    add(5'b00000, 0, 5'b01000, 3); add(5'b00000, 0, 5'b10000, 4);
    // Loop 3: halt from EXECUTE, then HALT ignores stalls, release.
    add(5'b11110, 0, 5'b00001, 0); add(5'b00000, 0, 5'b00010, 1);
    add(5'b00000, 1, 5'b00100, 2); add(5'b00000, 1, 5'b01000, 3);
    add(5'b00000, 1, 5'b10000, 4); add(5'b00000, 1, 5'b00000, 5);
    add(5'b11111, 1, 5'b00000, 5); add(5'b00000, 0, 5'b00000, 5);
    // Loop 4: halt early is ignored; stall_writeback beats halt for 2 cycles.
    add(5'b00000, 1, 5'b00001, 0); add(5'b00000, 1, 5'b00010, 1);
    add(5'b00000, 1, 5'b00100, 2); add(5'b00000, 1, 5'b01000, 3);
    add(5'b10000, 1, 5'b00000, 4); add(5'b10000, 1, 5'b00000, 4);
    add(5'b00000, 1, 5'b10000, 4); add(5'b00000, 0, 5'b00000, 5);
    add(5'b00000, 0, 5'b00001, 0);

    // Reset: phases low even with stalls clear.
    @(negedge clk); #1;
    chk("reset phase", 32'(ph), 32'd0);
    chk("reset state", 32'(phase_state), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("reset instret_cnt", 32'(instret_cnt), 32'd0);

    @(negedge clk); rst = 1'b0;
    run_vec(vq[0], "vec0");
    for (int i = 1; i < vq.size(); i++) begin
      @(negedge clk);
      run_vec(vq[i], $sformatf("vec%0d", i));
    end

    // Async reset mid-MEMORY: abandon instruction, no retire.
    @(negedge clk); v = '{stall: 5'b0, halt: 1'b0, ph: 5'b00010, st: 3'd1}; run_vec(v, "pre_rst dec");
    @(negedge clk); v.ph = 5'b00100; v.st = 3'd2; run_vec(v, "pre_rst exe");
    @(negedge clk); v.ph = 5'b01000; v.st = 3'd3; run_vec(v, "pre_rst mem");
    rst = 1'b1; #1;
    chk("midrst phase", 32'(ph), 32'd0);
    chk("midrst state", 32'(phase_state), 32'd0);
    chk("midrst cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("midrst instret_cnt", 32'(instret_cnt), 32'd0);
    exp_cyc = 4'd0; exp_ins = 4'd0;

    // 17 instructions with CNT_WIDTH=4: instret wraps 15 -> 0 -> 1.
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 17; n++) begin
      for (int s = 0; s < 5; s++) begin
        if (n != 0 || s != 0) @(negedge clk);
        v.stall = 5'b0; v.halt = 1'b0;
        v.ph = 5'(1 << s); v.st = 3'(s);
        run_vec(v, $sformatf("wrap n%0d s%0d", n, s));
      end
    end
    @(negedge clk); #1;
    chk("wrap instret final", 32'(instret_cnt), PERF ? 32'd1 : 32'd0);
    chk("wrap cycle final", 32'(cycle_cnt), PERF ? 32'd5 : 32'd0);   // 85 mod 16

    // HALT_ON_RESET=1 instance.
    chk("hor reset state", 32'(state_h), 32'd5);
    chk("hor reset halted", 32'(halted_h), 32'd1);
    chk("hor reset phase", 32'({hpw, hpm, hpe, hpd, hpf}), 32'd0);
    @(negedge clk); rst_h = 1'b0; halt_h = 1'b1;
    @(negedge clk); #1;
    chk("hor hold state", 32'(state_h), 32'd5);
    chk("hor hold cycle_cnt", cyc_h, 32'd0);
    halt_h = 1'b0;
    @(negedge clk); #1;
    chk("hor release state", 32'(state_h), 32'd0);
    chk("hor release fetch", 32'(hpf), 32'd1);
    chk("hor release halted", 32'(halted_h), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-002 Parameter HALT_ON_RESET, default 0: 1 means leave reset into HALT, 0 means leave reset into FETCH.
REQ-003 clk  in  1  CPU clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback  in  1 each  the named stage is not done and must be held.
REQ-006 halt_req  in  1  request to stop after the current instruction retires.
REQ-007 phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback  out  1 each  output-register enable of the named stage.
REQ-008 phase_state  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
REQ-009 halted  out  1  high while in HALT.
REQ-010 cycle_cnt  out  CNT_WIDTH  count of non-halted cycles.
REQ-011 instret_cnt  out  CNT_WIDTH  count of retired instructions.

Function
REQ-012 The FSM SHALL cycle FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH, one instruction per loop, with no overlap between instructions.
REQ-013 In each stage state the FSM SHALL hold while that stage's stall input is 1, and advance on the first edge where it is 0.
REQ-014 phase_X SHALL be combinational: high in exactly the last cycle of state X, i.e. (state==X) and not stall_X.
REQ-015 At most one phase_* output SHALL be high in any cycle; all phase_* are 0 in HALT.
REQ-016 Minimum loop latency SHALL be 5 cycles per instruction with no stalls; each stall cycle adds exactly 1 cycle.
REQ-017 When WRITEBACK completes with halt_req=1, the next state SHALL be HALT; with halt_req=0 it SHALL be FETCH.
REQ-018 halt_req SHALL be ignored in all other states and cycles; a pending instruction always retires.
REQ-019 In HALT, the FSM SHALL move to FETCH on the first edge where halt_req=0.
REQ-020 If halt_req and stall_writeback are both 1, the stall SHALL win; halt is evaluated only on WRITEBACK completion.
REQ-021 Stall inputs of stages other than the current state SHALL have no effect.
REQ-022 Unused state codes (6, 7) SHALL transition to FETCH on the next edge with all phase_* at 0.

Reset
REQ-023 While rst=1, all phase_* SHALL be forced to 0 regardless of stall inputs.
REQ-024 While rst=1, the state SHALL be FETCH (or HALT if HALT_ON_RESET=1), and halted SHALL reflect that state.
REQ-025 While rst=1, cycle_cnt=0 and instret_cnt=0.
REQ-026 Reset asserted mid-instruction SHALL abandon that instruction immediately, with no retire count.
REQ-027 The first active state SHALL begin on the first edge after rst falls.

Configuration
REQ-028 Macro PHASE_SEQUENCER_PERF_CNT_EN: when defined, the performance counters SHALL be implemented as follows.
- cycle_cnt +1 every cycle out of reset where the state is not HALT.
- instret_cnt +1 on every cycle where phase_writeback=1.
- Both counters wrap from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-029 When PHASE_SEQUENCER_PERF_CNT_EN is undefined, cycle_cnt and instret_cnt SHALL be constant 0 and no counter flops SHALL exist; the FSM is unchanged.

Verification
REQ-030 Release rst, all stalls 0, halt_req 0: phase_fetch..phase_writeback pulse on cycles 1..5, phase_fetch again on cycle 6; instret_cnt=1 after cycle 5.
REQ-031 Hold stall_decode=1 for 3 cycles in DECODE: phase_decode fires 3 cycles late; stall_memory toggling during DECODE has no effect; loop takes 8 cycles.
REQ-032 halt_req=1 from EXECUTE onward: WRITEBACK pulses once, then halted=1 and phase_state=5 with all phase_* 0. Drop halt_req: FETCH on the next edge, and cycle_cnt does not advance while halted.
REQ-033 halt_req=1 with stall_writeback=1 for 2 cycles: stays in WRITEBACK 2 extra cycles, then HALT; instret_cnt increments exactly once.
REQ-034 Assert rst asynchronously mid-MEMORY: phase_* go 0 the same cycle, state returns to FETCH, counters read 0, no retire is counted.
REQ-035 With CNT_WIDTH=4 and the macro defined, run 17 instructions: instret_cnt wraps 15 -> 0 and reads 1. With the macro undefined: both counters read 0 throughout.
